// File: rtl/gpu_pkg.sv
// Shared GPU core encodings and the ALU thread scheduler state type.
package gpu_pkg;

  localparam logic [2:0] CoreIdle    = 3'b000;
  localparam logic [2:0] CoreFetch   = 3'b001;
  localparam logic [2:0] CoreDecode  = 3'b010;
  localparam logic [2:0] CoreRequest = 3'b011;
  localparam logic [2:0] CoreWait    = 3'b100;
  localparam logic [2:0] CoreExecute = 3'b101;
  localparam logic [2:0] CoreUpdate  = 3'b110;
  localparam logic [2:0] CoreDone    = 3'b111;

  localparam logic [1:0] AluAdd = 2'b00;
  localparam logic [1:0] AluSub = 2'b01;
  localparam logic [1:0] AluMul = 2'b10;
  localparam logic [1:0] AluDiv = 2'b11;

  localparam logic AluOutArith   = 1'b0;
  localparam logic AluOutCompare = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } sched_state_e;

endpackage

// File: rtl/alu_thread_scheduler_thread_pick.sv
// Lowest-set-bit priority encoder over the pending-thread mask.
module thread_pick #(
  parameter int unsigned THREADS = 4,
  parameter int unsigned IdxW    = (THREADS > 1) ? $clog2(THREADS) : 1
) (
  input  logic [THREADS-1:0] mask,
  output logic [IdxW-1:0]    idx,
  output logic               valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < THREADS; i++) begin
      if (!valid && mask[i]) begin
        idx   = IdxW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_thread_scheduler.sv
// Shares one registered 8-bit ALU across all thread lanes, issuing one enabled
// lane per cycle during EXECUTE and capturing each result one cycle later.
module alu_thread_scheduler
  import gpu_pkg::*;
#(
  parameter int unsigned THREADS = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [2:0]           core_state,
  input  logic [THREADS-1:0]   thread_enable,
  input  logic [1:0]           decoded_alu_arithmetic_selector,
  input  logic                 decoded_alu_output_selector,
  input  logic [8*THREADS-1:0] rs_flat,
  input  logic [8*THREADS-1:0] rt_flat,
  output logic                 alu_busy,
  output logic                 alu_done,
  output logic [8*THREADS-1:0] alu_out_flat,
  output logic                 alu_enable,
  output logic [2:0]           alu_core_state,
  output logic [1:0]           alu_arith_sel,
  output logic                 alu_output_sel,
  output logic [7:0]           alu_rs,
  output logic [7:0]           alu_rt,
  input  logic [7:0]           alu_result
);

  localparam int unsigned IdxW = (THREADS > 1) ? $clog2(THREADS) : 1;

  sched_state_e         state_q;
  logic [THREADS-1:0]   pending_q;
  logic [THREADS-1:0]   pending_clr;
  logic [1:0]           arith_sel_q;
  logic                 output_sel_q;
  logic                 inflight_valid_q;
  logic [IdxW-1:0]      inflight_idx_q;
  logic [8*THREADS-1:0] results_q;
  logic [IdxW-1:0]      pick_idx;
  logic                 pick_valid;
  logic                 issuing;
  logic                 in_exec;
  logic [7:0]           lane_rs;
  logic [7:0]           lane_rt;

  thread_pick #(
    .THREADS(THREADS),
    .IdxW   (IdxW)
  ) u_thread_pick (
    .mask (pending_q),
    .idx  (pick_idx),
    .valid(pick_valid)
  );

  assign in_exec     = (core_state == CoreExecute);
  assign issuing     = (state_q == StIssue) && pick_valid;
  assign pending_clr = pending_q & ~(THREADS'(1) << pick_idx);

  always_comb begin
    lane_rs = '0;
    lane_rt = '0;
    for (int unsigned i = 0; i < THREADS; i++) begin
      if (pick_idx == IdxW'(i)) begin
        lane_rs = rs_flat[8*i +: 8];
        lane_rt = rt_flat[8*i +: 8];
      end
    end
  end

  // Everything toward the ALU is held at zero outside issue cycles so it only latches on issue.
  always_comb begin
    alu_enable     = issuing;
    alu_core_state = issuing ? CoreExecute : CoreIdle;
    alu_arith_sel  = issuing ? arith_sel_q : 2'b00;
    alu_output_sel = issuing ? output_sel_q : 1'b0;
    alu_rs         = issuing ? lane_rs : 8'h00;
    alu_rt         = issuing ? lane_rt : 8'h00;
  end

  assign alu_busy     = (state_q == StIssue) || (state_q == StDrain);
  assign alu_done     = (state_q == StDone);
  assign alu_out_flat = results_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= StIdle;
      pending_q        <= '0;
      arith_sel_q      <= 2'b00;
      output_sel_q     <= 1'b0;
      inflight_valid_q <= 1'b0;
      inflight_idx_q   <= '0;
      results_q        <= '0;
    end else begin
      // Capture is independent of state so an aborted batch still lands its last result.
      for (int unsigned i = 0; i < THREADS; i++) begin
        if (inflight_valid_q && (inflight_idx_q == IdxW'(i))) begin
          results_q[8*i +: 8] <= alu_result;
        end
      end
      inflight_valid_q <= issuing;
      if (issuing) begin
        inflight_idx_q <= pick_idx;
      end

      unique case (state_q)
        StIdle: begin
          if (in_exec) begin
            pending_q    <= thread_enable;
            arith_sel_q  <= decoded_alu_arithmetic_selector;
            output_sel_q <= decoded_alu_output_selector;
            state_q      <= (|thread_enable) ? StIssue : StDone;
          end
        end
        StIssue: begin
          if (!in_exec) begin
            pending_q <= '0;
            state_q   <= StIdle;
          end else begin
            pending_q <= pending_clr;
            if (pending_clr == '0) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          state_q <= in_exec ? StDone : StIdle;
        end
        StDone: begin
          if (!in_exec) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_thread_scheduler.sv
// Bench for alu_thread_scheduler: directed literal cases plus a queue-based model under random stimulus.
module tb_alu_thread_scheduler;

  localparam int unsigned THREADS = 4;
  localparam logic [2:0] Exec = 3'b101;
  localparam logic [2:0] Upd  = 3'b110;

  logic                 clock;
  logic                 reset;
  logic [2:0]           core_state;
  logic [THREADS-1:0]   thread_enable;
  logic [1:0]           arith_sel;
  logic                 output_sel;
  logic [8*THREADS-1:0] rs_flat;
  logic [8*THREADS-1:0] rt_flat;
  logic                 alu_busy;
  logic                 alu_done;
  logic [8*THREADS-1:0] alu_out_flat;
  logic                 alu_enable;
  logic [2:0]           alu_core_state;
  logic [1:0]           alu_arith_sel;
  logic                 alu_output_sel;
  logic [7:0]           alu_rs;
  logic [7:0]           alu_rt;
  logic [7:0]           alu_result;

  int n_cmp = 0;
  int n_bad = 0;

  alu_thread_scheduler #(
    .THREADS(THREADS)
  ) dut (
    .clock                          (clock),
    .reset                          (reset),
    .core_state                     (core_state),
    .thread_enable                  (thread_enable),
    .decoded_alu_arithmetic_selector(arith_sel),
    .decoded_alu_output_selector    (output_sel),
    .rs_flat                        (rs_flat),
    .rt_flat                        (rt_flat),
    .alu_busy                       (alu_busy),
    .alu_done                       (alu_done),
    .alu_out_flat                   (alu_out_flat),
    .alu_enable                     (alu_enable),
    .alu_core_state                 (alu_core_state),
    .alu_arith_sel                  (alu_arith_sel),
    .alu_output_sel                 (alu_output_sel),
    .alu_rs                         (alu_rs),
    .alu_rt                         (alu_rt),
    .alu_result                     (alu_result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] alu_f(input logic [1:0] a, input logic o,
                                       input logic [7:0] x, input logic [7:0] y);
    logic [7:0] r;
    if (o) begin
      r = {5'b0, x > y, x == y, x < y};
    end else begin
      case (a)
        2'b00:   r = x + y;
        2'b01:   r = x - y;
        2'b10:   r = x * y;
        default: r = (y == 8'h00) ? 8'h00 : x / y;
      endcase
    end
    return r;
  endfunction

  // Shared ALU: result registered one cycle after an issue.
  always @(posedge clock) begin
    if (reset) alu_result <= 8'h00;
    else if (alu_enable && alu_core_state == Exec)
      alu_result <= alu_f(alu_arith_sel, alu_output_sel, alu_rs, alu_rt);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: a queue of lanes still to issue, the lane whose result is in flight,
  // and flags for the drain cycle and the done window.
  int         q[$];
  bit         m_drain = 1'b0;
  bit         m_done  = 1'b0;
  int         m_fly   = -1;
  logic [7:0] m_fly_val;
  logic [7:0] m_res[THREADS];
  logic [1:0] m_as;
  logic       m_os;
  bit         model_on = 1'b0;

  initial begin
    for (int i = 0; i < THREADS; i++) m_res[i] = 8'h00;
    m_as = 2'b00;
    m_os = 1'b0;
  end

  always @(negedge clock) begin : model_blk
    bit iss;
    int ln;
    logic [31:0] exp_flat;
    if (model_on) begin
      iss = (q.size() > 0);
      ln  = iss ? q[0] : 0;
      for (int i = 0; i < THREADS; i++) exp_flat[8*i +: 8] = m_res[i];
      chk("busy", 32'(alu_busy), 32'(iss || m_drain));
      chk("done", 32'(alu_done), 32'(m_done));
      chk("enable", 32'(alu_enable), 32'(iss));
      chk("alu_core_state", 32'(alu_core_state), iss ? 32'd5 : 32'd0);
      chk("alu_rs", 32'(alu_rs), iss ? 32'(rs_flat[8*ln +: 8]) : 32'd0);
      chk("alu_rt", 32'(alu_rt), iss ? 32'(rt_flat[8*ln +: 8]) : 32'd0);
      chk("out_flat", alu_out_flat, exp_flat);
      if (iss) begin
        chk("arith_sel", 32'(alu_arith_sel), 32'(m_as));
        chk("output_sel", 32'(alu_output_sel), 32'(m_os));
      end
      if (reset) begin
        q.delete();
        m_drain = 1'b0;
        m_done  = 1'b0;
        m_fly   = -1;
        for (int i = 0; i < THREADS; i++) m_res[i] = 8'h00;
      end else begin
        if (m_fly >= 0) m_res[m_fly] = m_fly_val;
        m_fly = -1;
        if (iss) begin
          m_fly     = q.pop_front();
          m_fly_val = alu_f(m_as, m_os, rs_flat[8*m_fly +: 8], rt_flat[8*m_fly +: 8]);
          if (core_state != Exec) q.delete();
          else if (q.size() == 0) m_drain = 1'b1;
        end else if (m_drain) begin
          m_drain = 1'b0;
          m_done  = (core_state == Exec);
        end else if (m_done) begin
          if (core_state != Exec) m_done = 1'b0;
        end else if (core_state == Exec) begin
          for (int i = 0; i < THREADS; i++) if (thread_enable[i]) q.push_back(i);
          m_as = arith_sel;
          m_os = output_sel;
          if (q.size() == 0) m_done = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic leave();
    core_state = Upd;
    step();
  endtask

  // Starts a batch from IDLE and records which cycles issued and the first done cycle.
  task automatic run_batch(input logic [3:0] m, input logic [1:0] a, input logic [31:0] rs,
                           input logic [31:0] rt, output int done_cyc, output logic [15:0] en);
    thread_enable = m;
    arith_sel     = a;
    output_sel    = 1'b0;
    rs_flat       = rs;
    rt_flat       = rt;
    core_state    = Exec;
    done_cyc      = -1;
    en            = '0;
    for (int c = 0; c < 16 && done_cyc < 0; c++) begin
      @(negedge clock);
      if (alu_enable) en[c] = 1'b1;
      if (alu_done) done_cyc = c;
      step();
    end
  endtask

  initial begin
    int         dc;
    logic [15:0] en;
    bit         seen_done;

    reset         = 1'b1;
    core_state    = 3'b000;
    thread_enable = '0;
    arith_sel     = 2'b00;
    output_sel    = 1'b0;
    rs_flat       = '0;
    rt_flat       = '0;
    step();
    step();
    model_on = 1'b1;
    @(negedge clock);
    chk("reset_out_flat", alu_out_flat, 32'h0);
    chk("reset_outputs", {28'h0, alu_busy, alu_done, alu_enable, |alu_core_state}, 32'h0);
    step();
    reset = 1'b0;

    // Full mask ADD
    run_batch(4'b1111, 2'b00, 32'h04030201, 32'h281e140a, dc, en);
    chk("full_done_cycle", 32'(dc), 32'd6);
    chk("full_enable_cycles", 32'(en), 32'b11110);
    chk("full_results", alu_out_flat, 32'h2c21160b);
    leave();

    // Sparse mask SUB
    run_batch(4'b1010, 2'b01, 32'h09003200, 32'h09000800, dc, en);
    chk("sparse_done_cycle", 32'(dc), 32'd4);
    chk("sparse_enable_cycles", 32'(en), 32'b0110);
    chk("sparse_results", alu_out_flat, 32'h00212a0b);
    leave();

    // Empty mask
    run_batch(4'b0000, 2'b00, 32'h0, 32'h0, dc, en);
    chk("empty_done_cycle", 32'(dc), 32'd1);
    chk("empty_enable_cycles", 32'(en), 32'h0);
    leave();

    // Reset mid-batch
    thread_enable = 4'b1111;
    core_state    = Exec;
    step();
    step();
    reset      = 1'b1;
    core_state = Upd;
    step();
    reset = 1'b0;
    @(negedge clock);
    chk("midreset_out_flat", alu_out_flat, 32'h0);
    chk("midreset_flags", {29'h0, alu_busy, alu_done, alu_enable}, 32'h0);
    step();

    // Abort at cycle 2
    run_batch(4'b1111, 2'b00, 32'h04030201, 32'h281e140a, dc, en);
    chk("prefill_done_cycle", 32'(dc), 32'd6);
    leave();
    thread_enable = 4'b1111;
    rs_flat       = 32'h08070605;
    rt_flat       = 32'h05050505;
    core_state    = Exec;
    step();
    step();
    core_state = Upd;
    seen_done  = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (alu_done) seen_done = 1'b1;
      step();
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);
    chk("abort_results", alu_out_flat, 32'h2c210b0a);
    run_batch(4'b0001, 2'b00, 32'h00000001, 32'h00000001, dc, en);
    chk("after_abort_done_cycle", 32'(dc), 32'd3);
    chk("after_abort_results", alu_out_flat, 32'h2c210b02);
    leave();

    // Back-to-back MUL then DIV
    run_batch(4'b0001, 2'b10, 32'h00000006, 32'h00000007, dc, en);
    chk("mul_done_cycle", 32'(dc), 32'd3);
    chk("mul_lane0", 32'(alu_out_flat[7:0]), 32'd42);
    leave();
    run_batch(4'b0001, 2'b11, 32'h00000054, 32'h00000002, dc, en);
    chk("div_done_cycle", 32'(dc), 32'd3);
    chk("div_lane0", 32'(alu_out_flat[7:0]), 32'd42);
    leave();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rs_flat = $urandom;
      rt_flat = ($urandom_range(0, 3) == 0) ? rs_flat : $urandom;
      if ($urandom_range(0, 5) == 0) thread_enable = 4'($urandom);
      arith_sel  = 2'($urandom);
      output_sel = 1'($urandom);
      if ($urandom_range(0, 6) == 0)
        core_state = (core_state == Exec) ? 3'($urandom_range(0, 4)) : Exec;
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset      = 1'b0;
    core_state = 3'b000;
    for (int c = 0; c < 8; c++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
